// File: rtl/id_ex_stage_pkg.sv
// Shared ID/EX pipeline definitions: register-zero constant, NOP opcode and
// the control bundle carried from decode into execute.
package id_ex_stage_pkg;

    localparam logic [4:0] REG_ZERO     = 5'd0;
    localparam int         CTRL_ALUOP_W = 4;
    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_NOP = '0;

    typedef struct packed {
        logic                    regwrite;
        logic                    memread;
        logic                    memwrite;
        logic                    memtoreg;
        logic                    alusrc;
        logic [CTRL_ALUOP_W-1:0] aluop;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t CTRL_BUBBLE = '{regwrite: 1'b0, memread: 1'b0, memwrite: 1'b0,
                                            memtoreg: 1'b0, alusrc: 1'b0, aluop: ALUOP_NOP};

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard check: a load in EX whose destination is read
// by the instruction currently in ID.
module load_use_detect
    import id_ex_stage_pkg::*;
(
    input  logic       id_valid_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rs_i,
    input  logic       id_uses_rt_i,
    input  logic       ex_valid_i,
    input  logic       ex_memread_i,
    input  logic [4:0] ex_regdst_i,
    output logic       lu_o
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_uses_rs_i && (id_rs_i == ex_regdst_i);
    assign rt_hit = id_uses_rt_i && (id_rt_i == ex_regdst_i);
    assign lu_o   = id_valid_i && ex_valid_i && ex_memread_i &&
                    (ex_regdst_i != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// global hold and a same-cycle WB-to-ID operand bypass.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = CTRL_ALUOP_W,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               id_valid_i,
    input  logic [4:0]         id_rs_i,
    input  logic [4:0]         id_rt_i,
    input  logic               id_uses_rs_i,
    input  logic               id_uses_rt_i,
    input  logic [DATA_W-1:0]  id_rs_data_i,
    input  logic [DATA_W-1:0]  id_rt_data_i,
    input  logic [DATA_W-1:0]  id_imm_i,
    input  logic [4:0]         id_regdst_i,
    input  logic               id_regwrite_i,
    input  logic               id_memread_i,
    input  logic               id_memwrite_i,
    input  logic               id_memtoreg_i,
    input  logic               id_alusrc_i,
    input  logic [ALUOP_W-1:0] id_aluop_i,
    input  logic               wb_regwrite_i,
    input  logic [4:0]         wb_regdst_i,
    input  logic [DATA_W-1:0]  wb_data_i,
    input  logic               flush_i,
    input  logic               hold_i,
    output logic               ex_valid_o,
    output logic [4:0]         ex_rs_o,
    output logic [4:0]         ex_rt_o,
    output logic [4:0]         ex_regdst_o,
    output logic [DATA_W-1:0]  ex_rs_data_o,
    output logic [DATA_W-1:0]  ex_rt_data_o,
    output logic [DATA_W-1:0]  ex_imm_o,
    output logic               ex_regwrite_o,
    output logic               ex_memread_o,
    output logic               ex_memwrite_o,
    output logic               ex_memtoreg_o,
    output logic               ex_alusrc_o,
    output logic [ALUOP_W-1:0] ex_aluop_o,
    output logic               stall_o,
    output logic [CNT_W-1:0]   bubble_cnt_o
);

    logic              lu;
    logic              ex_valid_q;
    id_ex_ctrl_t       ctrl_q, ctrl_d;
    logic [4:0]        rs_q, rt_q, regdst_q;
    logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
    logic [DATA_W-1:0] rs_data_d, rt_data_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              wb_live;

    load_use_detect u_lu (
        .id_valid_i   (id_valid_i),
        .id_rs_i      (id_rs_i),
        .id_rt_i      (id_rt_i),
        .id_uses_rs_i (id_uses_rs_i),
        .id_uses_rt_i (id_uses_rt_i),
        .ex_valid_i   (ex_valid_q),
        .ex_memread_i (ctrl_q.memread),
        .ex_regdst_i  (regdst_q),
        .lu_o         (lu)
    );

    assign stall_o = lu && !flush_i && !hold_i;

    // Register file writes at the end of this cycle, so ID's read data is stale.
    assign wb_live   = wb_regwrite_i && (wb_regdst_i != REG_ZERO);
    assign rs_data_d = (wb_live && wb_regdst_i == id_rs_i) ? wb_data_i : id_rs_data_i;
    assign rt_data_d = (wb_live && wb_regdst_i == id_rt_i) ? wb_data_i : id_rt_data_i;

    always_comb begin
        ctrl_d          = CTRL_BUBBLE;
        ctrl_d.regwrite = id_valid_i && id_regwrite_i && (id_regdst_i != REG_ZERO);
        ctrl_d.memread  = id_valid_i && id_memread_i;
        ctrl_d.memwrite = id_valid_i && id_memwrite_i;
        ctrl_d.memtoreg = id_valid_i && id_memtoreg_i;
        ctrl_d.alusrc   = id_valid_i && id_alusrc_i;
        ctrl_d.aluop    = id_valid_i ? CTRL_ALUOP_W'(id_aluop_i) : ALUOP_NOP;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_valid_q <= 1'b0;
            ctrl_q     <= CTRL_BUBBLE;
            rs_q       <= '0;
            rt_q       <= '0;
            regdst_q   <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            cnt_q      <= '0;
        end else if (!hold_i) begin
            if (flush_i || lu) begin
                ex_valid_q <= 1'b0;
                ctrl_q     <= CTRL_BUBBLE;
                rs_q       <= '0;
                rt_q       <= '0;
                regdst_q   <= '0;
                rs_data_q  <= '0;
                rt_data_q  <= '0;
                imm_q      <= '0;
                // A flushed instruction is never counted as a load-use bubble.
                if (stall_o && cnt_q != {CNT_W{1'b1}})
                    cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                ex_valid_q <= id_valid_i;
                ctrl_q     <= ctrl_d;
                rs_q       <= id_rs_i;
                rt_q       <= id_rt_i;
                regdst_q   <= id_regdst_i;
                rs_data_q  <= rs_data_d;
                rt_data_q  <= rt_data_d;
                imm_q      <= id_imm_i;
            end
        end
    end

    assign ex_valid_o    = ex_valid_q;
    assign ex_rs_o       = rs_q;
    assign ex_rt_o       = rt_q;
    assign ex_regdst_o   = regdst_q;
    assign ex_rs_data_o  = rs_data_q;
    assign ex_rt_data_o  = rt_data_q;
    assign ex_imm_o      = imm_q;
    assign ex_regwrite_o = ctrl_q.regwrite;
    assign ex_memread_o  = ctrl_q.memread;
    assign ex_memwrite_o = ctrl_q.memwrite;
    assign ex_memtoreg_o = ctrl_q.memtoreg;
    assign ex_alusrc_o   = ctrl_q.alusrc;
    assign ex_aluop_o    = ALUOP_W'(ctrl_q.aluop);
    assign bubble_cnt_o  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage; a second narrow-counter instance
// shares the stimulus to reach counter saturation quickly.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_uses_rs, id_uses_rt;
    logic [4:0]  id_rs, id_rt, id_regdst;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc;
    logic [3:0]  id_aluop;
    logic        wb_regwrite;
    logic [4:0]  wb_regdst;
    logic [31:0] wb_data;
    logic        flush, hold;

    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, stall;
    logic [4:0]  ex_rs, ex_rt, ex_regdst;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [3:0]  ex_aluop;
    logic [15:0] bcnt;

    logic        s_valid, s_regwrite, s_memread, s_memwrite, s_memtoreg, s_alusrc, s_stall;
    logic [4:0]  s_rs, s_rt, s_regdst;
    logic [31:0] s_rs_data, s_rt_data, s_imm;
    logic [3:0]  s_aluop;
    logic [2:0]  s_bcnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt), .id_rs_data_i(id_rs_data),
        .id_rt_data_i(id_rt_data), .id_imm_i(id_imm), .id_regdst_i(id_regdst),
        .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .id_memwrite_i(id_memwrite),
        .id_memtoreg_i(id_memtoreg), .id_alusrc_i(id_alusrc), .id_aluop_i(id_aluop),
        .wb_regwrite_i(wb_regwrite), .wb_regdst_i(wb_regdst), .wb_data_i(wb_data),
        .flush_i(flush), .hold_i(hold), .ex_valid_o(ex_valid), .ex_rs_o(ex_rs), .ex_rt_o(ex_rt),
        .ex_regdst_o(ex_regdst), .ex_rs_data_o(ex_rs_data), .ex_rt_data_o(ex_rt_data),
        .ex_imm_o(ex_imm), .ex_regwrite_o(ex_regwrite), .ex_memread_o(ex_memread),
        .ex_memwrite_o(ex_memwrite), .ex_memtoreg_o(ex_memtoreg), .ex_alusrc_o(ex_alusrc),
        .ex_aluop_o(ex_aluop), .stall_o(stall), .bubble_cnt_o(bcnt)
    );

    id_ex_stage #(.CNT_W(3)) dut_s (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt), .id_rs_data_i(id_rs_data),
        .id_rt_data_i(id_rt_data), .id_imm_i(id_imm), .id_regdst_i(id_regdst),
        .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .id_memwrite_i(id_memwrite),
        .id_memtoreg_i(id_memtoreg), .id_alusrc_i(id_alusrc), .id_aluop_i(id_aluop),
        .wb_regwrite_i(wb_regwrite), .wb_regdst_i(wb_regdst), .wb_data_i(wb_data),
        .flush_i(flush), .hold_i(hold), .ex_valid_o(s_valid), .ex_rs_o(s_rs), .ex_rt_o(s_rt),
        .ex_regdst_o(s_regdst), .ex_rs_data_o(s_rs_data), .ex_rt_data_o(s_rt_data),
        .ex_imm_o(s_imm), .ex_regwrite_o(s_regwrite), .ex_memread_o(s_memread),
        .ex_memwrite_o(s_memwrite), .ex_memtoreg_o(s_memtoreg), .ex_alusrc_o(s_alusrc),
        .ex_aluop_o(s_aluop), .stall_o(s_stall), .bubble_cnt_o(s_bcnt)
    );

    typedef struct {
        logic        v;
        logic [4:0]  rs, rt;
        logic        urs, urt;
        logic [31:0] rsd, rtd;
        logic [4:0]  rd;
        logic        rw, mr, wbw;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic        fl, hd;
        logic        e_stall, e_v;
        logic [4:0]  e_rd;
        logic        e_rw, e_mr;
        logic [31:0] e_rsd, e_rtd;
        logic [3:0]  e_op;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    // memtoreg/alusrc/memwrite follow memread; aluop follows rd[3:0].
    task automatic drive(input vec_t t);
        id_valid    = t.v;   id_rs = t.rs;         id_rt = t.rt;
        id_uses_rs  = t.urs; id_uses_rt = t.urt;
        id_rs_data  = t.rsd; id_rt_data = t.rtd;   id_imm = t.rsd ^ 32'hFFFF;
        id_regdst   = t.rd;  id_regwrite = t.rw;   id_memread = t.mr;
        id_memwrite = t.mr;  id_memtoreg = t.mr;   id_alusrc = t.mr;
        id_aluop    = t.rd[3:0];
        wb_regwrite = t.wbw; wb_regdst = t.wbrd;   wb_data = t.wbd;
        flush       = t.fl;  hold = t.hd;
    endtask

    task automatic step(input vec_t t, input int idx);
        @(negedge clk);
        drive(t);
        #1;
        chk("stall", idx, 32'(stall), 32'(t.e_stall));
        @(posedge clk);
        #1;
        chk("ex_valid", idx, 32'(ex_valid), 32'(t.e_v));
        chk("ex_regdst", idx, 32'(ex_regdst), 32'(t.e_rd));
        chk("ex_regwrite", idx, 32'(ex_regwrite), 32'(t.e_rw));
        chk("ex_memread", idx, 32'(ex_memread), 32'(t.e_mr));
        chk("ex_memtoreg", idx, 32'(ex_memtoreg), 32'(t.e_mr));
        chk("ex_alusrc", idx, 32'(ex_alusrc), 32'(t.e_mr));
        chk("ex_memwrite", idx, 32'(ex_memwrite), 32'(t.e_mr));
        chk("ex_rs_data", idx, ex_rs_data, t.e_rsd);
        chk("ex_rt_data", idx, ex_rt_data, t.e_rtd);
        chk("ex_aluop", idx, 32'(ex_aluop), 32'(t.e_op));
        chk("bubble_cnt", idx, 32'(bcnt), 32'(t.e_cnt));
    endtask

    initial begin
        vec_t lw, use_v;
        //            v rs rt urs urt rsd      rtd      rd rw mr wbw wbrd wbd        fl hd  stl v rd rw mr e_rsd    e_rtd    op cnt
        vecs[0]  = '{1, 1, 2, 1, 1, 'h10,    'h20,    3, 1, 0, 0, 0,  0,         0, 0,  0, 1, 3, 1, 0, 'h10,    'h20,    3, 0};
        vecs[1]  = '{1, 3, 5, 1, 0, 'h100,   'h101,   5, 1, 1, 0, 0,  0,         0, 0,  0, 1, 5, 1, 1, 'h100,   'h101,   5, 0};
        vecs[2]  = '{1, 5, 2, 1, 1, 'h55,    'h56,    6, 1, 0, 0, 0,  0,         0, 0,  1, 0, 0, 0, 0, 0,       0,       0, 1};
        vecs[3]  = '{1, 5, 2, 1, 1, 'h55,    'h56,    6, 1, 0, 0, 0,  0,         0, 0,  0, 1, 6, 1, 0, 'h55,    'h56,    6, 1};
        vecs[4]  = '{1, 1, 9, 1, 0, 'h200,   'h201,   5, 1, 1, 0, 0,  0,         0, 0,  0, 1, 5, 1, 1, 'h200,   'h201,   5, 1};
        vecs[5]  = '{1, 2, 5, 1, 0, 'h300,   'h301,   8, 1, 0, 0, 0,  0,         0, 0,  0, 1, 8, 1, 0, 'h300,   'h301,   8, 1};
        vecs[6]  = '{1, 1, 3, 1, 0, 'h400,   'h401,   0, 1, 1, 0, 0,  0,         0, 0,  0, 1, 0, 0, 1, 'h400,   'h401,   0, 1};
        vecs[7]  = '{1, 0, 0, 1, 1, 'h500,   'h501,   9, 1, 0, 0, 0,  0,         0, 0,  0, 1, 9, 1, 0, 'h500,   'h501,   9, 1};
        vecs[8]  = '{1, 7, 2, 1, 1, 'h1111,  'h22,    10,1, 0, 1, 7,  'hDEAD,    0, 0,  0, 1, 10,1, 0, 'hDEAD,  'h22,    10,1};
        vecs[9]  = '{1, 0, 2, 1, 1, 'h1111,  'h22,    11,1, 0, 1, 0,  'hDEAD,    0, 0,  0, 1, 11,1, 0, 'h1111,  'h22,    11,1};
        vecs[10] = '{1, 7, 7, 1, 1, 'h2222,  'h3333,  12,1, 0, 0, 7,  'hDEAD,    0, 0,  0, 1, 12,1, 0, 'h2222,  'h3333,  12,1};
        vecs[11] = '{1, 1, 4, 1, 1, 'hA,     'hB,     13,1, 0, 1, 4,  'hBEEF,    0, 0,  0, 1, 13,1, 0, 'hA,     'hBEEF,  13,1};
        vecs[12] = '{1, 1, 2, 1, 0, 'h600,   'h601,   5, 1, 1, 0, 0,  0,         0, 0,  0, 1, 5, 1, 1, 'h600,   'h601,   5, 1};
        vecs[13] = '{1, 5, 2, 1, 1, 'h700,   'h701,   6, 1, 0, 0, 0,  0,         1, 0,  0, 0, 0, 0, 0, 0,       0,       0, 1};
        vecs[14] = '{1, 1, 2, 1, 0, 'h600,   'h601,   5, 1, 1, 0, 0,  0,         0, 0,  0, 1, 5, 1, 1, 'h600,   'h601,   5, 1};
        vecs[15] = '{1, 5, 2, 1, 1, 'h700,   'h701,   6, 1, 0, 0, 0,  0,         1, 1,  0, 1, 5, 1, 1, 'h600,   'h601,   5, 1};
        vecs[16] = '{1, 5, 2, 1, 1, 'h700,   'h701,   6, 1, 0, 0, 0,  0,         1, 1,  0, 1, 5, 1, 1, 'h600,   'h601,   5, 1};
        vecs[17] = '{1, 5, 2, 1, 1, 'h700,   'h701,   6, 1, 0, 0, 0,  0,         1, 1,  0, 1, 5, 1, 1, 'h600,   'h601,   5, 1};
        vecs[18] = '{1, 5, 2, 1, 1, 'h700,   'h701,   6, 1, 0, 0, 0,  0,         1, 0,  0, 0, 0, 0, 0, 0,       0,       0, 1};
        vecs[19] = '{0, 3, 2, 1, 1, 'h800,   'h801,   12,1, 1, 0, 0,  0,         0, 0,  0, 0, 12,0, 0, 'h800,   'h801,   0, 1};

        // Reset with busy ID inputs: nothing may leak into EX.
        rst = 1'b1;
        drive(vecs[1]);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 0, 32'(ex_valid), 0);
        chk("rst_ctrl", 0, 32'({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc}), 0);
        chk("rst_fields", 0, 32'({ex_rs, ex_rt, ex_regdst, ex_aluop}), 0);
        chk("rst_data", 0, ex_rs_data | ex_rt_data | ex_imm, 0);
        chk("rst_cnt", 0, 32'(bcnt), 0);
        chk("rst_stall", 0, 32'(stall), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) step(vecs[i], i);

        // Alternate rs/rt load-use hazards; narrow counter must pin at 7.
        lw    = vecs[12];
        use_v = vecs[2];
        for (int k = 0; k < 8; k++) begin
            lw.e_cnt = 16'(1 + k);
            step(lw, 100 + k);
            use_v.rs  = (k % 2 == 0) ? 5'd5 : 5'd1;
            use_v.rt  = (k % 2 == 0) ? 5'd2 : 5'd5;
            use_v.e_cnt = 16'(2 + k);
            step(use_v, 200 + k);
            chk("sat_cnt", k, 32'(s_bcnt), (k + 2 > 7) ? 32'd7 : 32'(k + 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS pipeline, with load-use hazard detection, bubble insertion, branch flush and a WB-to-ID same-cycle bypass.
- Its registered ex_* outputs are the EX-stage source fields (rs, rt, regdst, regwrite) that the EX forwarding logic compares against the MEM and WB destinations.
- Sits between the decode/register-file stage and the EX-stage ALU operand muxes.

Parameters:
- DATA_W, 32, width of operand, immediate and write-back data
- ALUOP_W, 4, width of the ALU operation code
- CNT_W, 16, width of the saturating bubble counter

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- id_valid_i  in  1  ID holds a real instruction
- id_rs_i, id_rt_i  in  5 each  source register numbers
- id_uses_rs_i, id_uses_rt_i  in  1 each  instruction actually reads rs / rt
- id_rs_data_i, id_rt_data_i  in  DATA_W each  register-file read data
- id_imm_i  in  DATA_W  sign/zero-extended immediate
- id_regdst_i  in  5  destination register
- id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i, id_alusrc_i  in  1 each  control bits
- id_aluop_i  in  ALUOP_W  ALU operation
- wb_regwrite_i  in  1  WB stage writes the register file this cycle
- wb_regdst_i  in  5  WB destination register
- wb_data_i  in  DATA_W  WB write data
- flush_i  in  1  taken branch/jump resolved; kill the ID instruction
- hold_i  in  1  memory-busy freeze of the whole pipeline
- ex_valid_o  out  1  EX holds a real instruction
- ex_rs_o, ex_rt_o, ex_regdst_o  out  5 each  registered register fields
- ex_rs_data_o, ex_rt_data_o, ex_imm_o  out  DATA_W each  registered data
- ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o, ex_alusrc_o  out  1 each  registered control
- ex_aluop_o  out  ALUOP_W  registered ALU operation
- stall_o  out  1  combinational; freeze PC and IF/ID this cycle
- bubble_cnt_o  out  CNT_W  count of load-use bubbles inserted, saturating

Behaviour:
- Reset: every ex_* output is 0 and bubble_cnt_o is 0 on the first rising edge with rst_i=1. stall_o is combinational and is 0 whenever ex_valid_o is 0, so it is also 0 after reset. Reset overrides all other inputs.
- Load-use detect (combinational), lu is true when all of the following hold:
  - id_valid_i, ex_valid_o and ex_memread_o are all 1
  - ex_regdst_o is not 0
  - (id_uses_rs_i and id_rs_i==ex_regdst_o) or (id_uses_rt_i and id_rt_i==ex_regdst_o)
- stall_o = lu and not flush_i and not hold_i.
- Per-edge priority, highest first:
  1. rst_i: clear everything.
  2. hold_i: all ex_* registers and bubble_cnt_o keep their values. flush_i is ignored; its source keeps asserting it until hold_i drops.
  3. flush_i: load a bubble.
  4. lu: load a bubble and increment bubble_cnt_o.
  5. Otherwise capture the ID fields.
- Bubble: ex_valid_o and all control outputs (regwrite, memread, memwrite, memtoreg, alusrc, aluop) become 0. Register-number and data fields are don't-care but are driven to 0.
- Capture rules:
  - ex_valid_o takes id_valid_i.
  - Control outputs take their ID values, gated by id_valid_i.
  - ex_regwrite_o is forced to 0 when id_regdst_i is 0, so the EX forwarding compare never matches $zero.
- WB bypass at capture: if wb_regwrite_i=1, wb_regdst_i is not 0 and wb_regdst_i==id_rs_i, ex_rs_data_o takes wb_data_i instead of id_rs_data_i. The same rule applies independently to rt.
- Latency: exactly one cycle from ID to EX outputs. A load-use hazard costs exactly one bubble, because on the next cycle the load has left EX and lu deasserts.
- bubble_cnt_o stops at 2^CNT_W-1; it never wraps.
- Simultaneous flush_i and lu: a bubble is loaded, the counter is unchanged, and stall_o=0.

Decomposition:
- Shared pipeline package holds:
  - REG_ZERO = 5'd0
  - ALUOP_NOP = 0
  - a bundle typedef for the ID/EX control fields (regwrite, memread, memwrite, memtoreg, alusrc, aluop)
- One natural sub-module, load_use_detect: purely combinational, producing lu. The stage instantiates it; the register bank stays in id_ex_stage.

Test Plan:
- Reset and capture: hold rst_i=1 for 2 cycles with nonzero ID inputs -> all ex_* = 0 and bubble_cnt_o=0. Then release reset and present add rd=3, rs=1, rt=2, data 0x10/0x20 -> the next cycle shows ex_valid_o=1, ex_regdst_o=3, ex_regwrite_o=1, ex_rs_data_o=0x10.
- Load-use: lw rd=5 in EX, then ID add rs=5, uses_rs=1 -> stall_o=1 for one cycle, followed by an EX bubble (ex_valid_o=0, ex_regwrite_o=0). bubble_cnt_o goes 0 to 1, and the add enters EX on the following cycle.
- No false stall, each case giving stall_o=0:
  - lw to $0 followed by a use of $0
  - lw rd=5 followed by an instruction with rt=5 but uses_rt=0
- WB bypass: wb_regwrite_i=1, wb_regdst_i=7, wb_data_i=0xDEAD while ID rs=7 with id_rs_data_i=0x1111 -> ex_rs_data_o=0xDEAD. Repeat with wb_regdst_i=0 -> ex_rs_data_o=0x1111.
- Flush versus hold:
  - flush_i=1 together with a load-use condition -> bubble, stall_o=0, counter unchanged.
  - hold_i=1 for 3 cycles with flush_i=1 -> ex_* unchanged; the bubble appears on the edge after hold_i drops.
- Saturation and $zero write: preset the counter to 0xFFFF with CNT_W=16 and trigger one more bubble -> count stays 0xFFFF. Separately, an ID instruction with regdst=0 and regwrite=1 -> ex_regwrite_o=0.
